decode_ibuf: RTL and testbench

- Parametrised instruction buffer between fetch and decode.
- Decouples fetch from decode stalls. Holds up to DEPTH fetched instructions with their PC and fetch-fault status.
- Presents the oldest entry to decode through a valid/ready handshake.
- Supports a single-cycle flush on branch/jump redirect or trap. Optionally fences the stream after a fetch fault, so nothing younger than a faulting instruction reaches decode.

---
 rtl/decode_ibuf_pkg.sv | 14 +
 rtl/decode_ibuf.sv | 69 ++++++
 tb/tb_decode_ibuf.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/decode_ibuf_pkg.sv
// decode_ibuf_pkg: shared fetch/decode buffer types and default depth
package decode_ibuf_pkg;
  typedef logic        u1;
  typedef logic [3:0]  u4;
  typedef logic [31:0] u32;
  typedef logic [63:0] addr_t;
  typedef struct packed {
    addr_t pc;
    u32    raw_instr;
    u1     err;
    u4     code;
  } ibuf_entry_t;
  localparam int IBUF_DEPTH = 4;
endpackage

// File: rtl/decode_ibuf.sv
// decode_ibuf: circular instruction buffer between fetch and decode with flush and fault fence
module decode_ibuf
  import decode_ibuf_pkg::*;
#(
  parameter int DEPTH       = IBUF_DEPTH,
  parameter int PC_W        = 64,
  parameter int ILEN        = 32,
  parameter int CODE_W      = 4,
  parameter int FAULT_FENCE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  input  logic                       in_err,
  input  logic [CODE_W-1:0]          in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic                       out_err,
  output logic [CODE_W-1:0]          out_code,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fenced
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ILEN-1:0]   instr;
    logic              err;
    logic [CODE_W-1:0] code;
  } ent_t;
  ent_t mem [DEPTH];
  ent_t hd;
  logic [AW-1:0] head, tail;
  logic enq, store, deq;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign enq       = in_valid & in_ready & ~flush;
  assign store     = enq & ~fenced;
  assign deq       = out_valid & out_ready & ~flush;
  assign hd        = mem[head];
  assign out_pc    = hd.pc;
  assign out_instr = hd.instr;
  assign out_code  = hd.code;
  assign out_err   = out_valid & hd.err;
  always_ff @(posedge clk)
    if (store) mem[tail] <= '{in_pc, in_instr, in_err, in_code};
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      fenced <= 1'b0;
    end else begin
      if (store) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + CW'(store) - CW'(deq);
      if (FAULT_FENCE != 0 && store && in_err) fenced <= 1'b1;
    end
  end
  a_count: assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
  a_err:   assert property (@(posedge clk) disable iff (reset) !out_valid |-> !out_err);
  a_ptr:   assert property (@(posedge clk) disable iff (reset) tail == head + AW'(count));
endmodule

// File: tb/tb_decode_ibuf.sv
// tb_decode_ibuf: scoreboard bench for decode_ibuf with fault fence on (index 1) and off (index 0)
module tb_decode_ibuf;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
    logic [3:0]  code;
  } exp_t;
  logic clk, reset, in_valid, in_err, out_ready, flush;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [3:0]  in_code;
  logic        ir [2], ov [2], oe [2], fe [2];
  logic [63:0] op [2];
  logic [31:0] oi [2];
  logic [3:0]  oc [2];
  logic [2:0]  cnt [2];
  int   nchk, nerr;
  int   mc [2];
  bit   mf [2];
  exp_t sb0 [$];
  exp_t sb1 [$];

  decode_ibuf #(.DEPTH(4), .FAULT_FENCE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_pc(in_pc),
    .in_instr(in_instr), .in_err(in_err), .in_code(in_code), .out_valid(ov[1]),
    .out_ready(out_ready), .out_pc(op[1]), .out_instr(oi[1]), .out_err(oe[1]),
    .out_code(oc[1]), .flush(flush), .count(cnt[1]), .fenced(fe[1]));
  decode_ibuf #(.DEPTH(4), .FAULT_FENCE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_pc(in_pc),
    .in_instr(in_instr), .in_err(in_err), .in_code(in_code), .out_valid(ov[0]),
    .out_ready(out_ready), .out_pc(op[0]), .out_instr(oi[0]), .out_err(oe[0]),
    .out_code(oc[0]), .flush(flush), .count(cnt[0]), .fenced(fe[0]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0;
      mf[k] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic tick(input logic v, input logic [63:0] pc, input logic e,
                      input logic [3:0] c, input logic r, input logic f);
    exp_t h, n;
    logic [31:0] lo;
    bit st, dq;
    lo = pc[31:0];
    n = '{pc, lo ^ 32'h5a5a_0f0f, e, c};
    in_valid = v; in_pc = pc; in_instr = n.instr; in_err = e; in_code = c;
    out_ready = r; flush = f;
    #1;
    for (int k = 0; k < 2; k++) begin
      nchk += 5;
      if (ov[k] !== (mc[k] != 0)) begin
        nerr++; $display("FAIL out_valid[%0d] got %b exp %b", k, ov[k], mc[k] != 0);
      end
      if (ir[k] !== (mc[k] != 4)) begin
        nerr++; $display("FAIL in_ready[%0d] got %b exp %b", k, ir[k], mc[k] != 4);
      end
      if (cnt[k] !== 3'(mc[k])) begin
        nerr++; $display("FAIL count[%0d] got %0d exp %0d", k, cnt[k], mc[k]);
      end
      if (fe[k] !== mf[k]) begin
        nerr++; $display("FAIL fenced[%0d] got %b exp %b", k, fe[k], mf[k]);
      end
      if (mc[k] == 0 && oe[k] !== 1'b0) begin
        nerr++; $display("FAIL idle_err[%0d] got %b exp 0", k, oe[k]);
      end else if (mc[k] != 0 && oe[k] === 1'bx) begin
        nerr++; $display("FAIL head_err_x[%0d] got %b exp 0/1", k, oe[k]);
      end
      dq = r && mc[k] != 0 && !f;
      st = v && mc[k] != 4 && !f && !mf[k];
      if (dq) begin
        h = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        nchk++;
        if ({op[k], oi[k], oe[k], oc[k]} !== h) begin
          nerr++;
          $display("FAIL head[%0d] got pc=%h instr=%h err=%b code=%h exp pc=%h instr=%h err=%b code=%h",
                   k, op[k], oi[k], oe[k], oc[k], h.pc, h.instr, h.err, h.code);
        end
      end
      if (st) begin
        if (k == 0) sb0.push_back(n); else sb1.push_back(n);
        if (k == 1 && e) mf[k] = 1'b1;
      end
      mc[k] = mc[k] + int'(st) - int'(dq);
    end
    if (f) clear_model();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic v, input logic [63:0] pc, input logic r, input logic f);
    in_valid = v; in_pc = pc; in_instr = pc[31:0]; in_err = 1'b0; in_code = 4'h0;
    out_ready = r; flush = f; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset(1'b1, 64'hdead, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      nchk += 5;
      if (cnt[k] !== 3'd0) begin nerr++; $display("FAIL rst_count[%0d] got %0d exp 0", k, cnt[k]); end
      if (ov[k] !== 1'b0) begin nerr++; $display("FAIL rst_out_valid[%0d] got %b exp 0", k, ov[k]); end
      if (ir[k] !== 1'b1) begin nerr++; $display("FAIL rst_in_ready[%0d] got %b exp 1", k, ir[k]); end
      if (fe[k] !== 1'b0) begin nerr++; $display("FAIL rst_fenced[%0d] got %b exp 0", k, fe[k]); end
      if (oe[k] !== 1'b0) begin nerr++; $display("FAIL rst_out_err[%0d] got %b exp 0", k, oe[k]); end
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) tick(1'b1, 64'h8000_0000 + 64'(4*i), 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    tick(1'b1, 64'h100, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) tick(1'b1, 64'h100 + 64'(4*i), 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) tick(1'b1, 64'h400 + 64'(4*i), 1'b0, 4'(i), 1'b0, 1'b0);
    tick(1'b1, 64'h410, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    tick(1'b1, 64'h4ff, 1'b0, 4'h0, 1'b1, 1'b1);
    tick(1'b1, 64'h200, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_fence();
    tick(1'b1, 64'h300, 1'b1, 4'h1, 1'b0, 1'b0);
    tick(1'b1, 64'h304, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 64'h308, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick(1'b1, 64'h30c, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 64'h500, 1'b1, 4'h3, 1'b0, 1'b0);
    tick(1'b1, 64'h504, 1'b0, 4'h0, 1'b0, 1'b0);
    do_reset(1'b1, 64'h5ff, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b1, 64'h600, 1'b0, 4'h2, 1'b0, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    nchk = 0; nerr = 0;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_err = 1'b0;
    in_code = '0; out_ready = 1'b0; flush = 1'b0;
    clear_model();
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_flush();
    test_fence();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
